load_store_ctrl: RTL and testbench

LOAD_STORE_CTRL -- requirements
Module: load_store_ctrl

---
 rtl/load_store_ctrl.sv | 146 ++++++++++++++
 tb/tb_load_store_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_ctrl.sv
// rtl/load_store_ctrl.sv - single-outstanding load/store controller with sub-word read-modify-write
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject misaligned half/word accesses with resp_err.
module load_store_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [6:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_wr_en,
  output logic [4:0]  mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_rd_en,
  output logic [4:0]  mem_rd_addr,
  input  logic [31:0] mem_rd_data
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

  state_t      state, state_nx;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [6:0]  addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] shifted;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;
  logic [31:0] merged;

`ifdef LSU_MISALIGN_CHECK_EN
  logic        err_q;
  logic        misalign;
  // Half needs addr[0]=0, word (size 1x) needs addr[1:0]=0
  assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                    (req_size[1] && (req_addr[1:0] != 2'b00));
`endif

  // State register; synchronous reset returns to IDLE and aborts any in-flight op
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Request latch on accept; WAIT captures either the load result or the merged store word
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 7'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
`ifdef LSU_MISALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
`ifdef LSU_MISALIGN_CHECK_EN
        err_q   <= misalign;
`endif
      end
      if (state == WAIT) begin
        if (we_q) wdata_q <= merged;
        else      rdata_q <= load_val;
      end
    end
  end

  // Lane extraction with sign/zero extension, and lane merge for sub-word stores
  always_comb begin
    shifted   = mem_rd_data >> {addr_q[1:0], 3'b000};
    lane_byte = shifted[7:0];
    lane_half = addr_q[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
    case (size_q)
      2'b00:   load_val = uns_q ? {24'd0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load_val = uns_q ? {16'd0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load_val = mem_rd_data;
    endcase
    merged = mem_rd_data;
    if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
    else                 merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  // Next-state decode and output drive; rst gates the strobes so an aborted op never writes
  always_comb begin
    state_nx    = state;
    req_ready   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    resp_rdata  = rdata_q;
    mem_rd_addr = addr_q[6:2];
    mem_wr_addr = addr_q[6:2];
    mem_wr_data = wdata_q;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
`ifdef LSU_MISALIGN_CHECK_EN
          if (misalign) state_nx = RESP;
          else
`endif
          if (req_we && req_size[1]) state_nx = WR;
          else                       state_nx = RD;
        end
      end
      RD: begin
        mem_rd_en = ~rst;
        state_nx  = WAIT;
      end
      WAIT: state_nx = we_q ? WR : RESP;
      WR: begin
        mem_wr_en = ~rst;
        state_nx  = RESP;
      end
      RESP: begin
        resp_valid = ~rst;
        if (we_q) resp_rdata = 32'd0;
`ifdef LSU_MISALIGN_CHECK_EN
        if (err_q) begin
          resp_err   = 1'b1;
          resp_rdata = 32'd0;
        end
`endif
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_ctrl.sv
// tb/tb_load_store_ctrl.sv - self-checking bench for load_store_ctrl with a registered-read memory model
module tb_load_store_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_wr_en;
  logic [4:0]  mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_rd_en;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;

  load_store_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // Memory model with a bench-side preload port
  logic [31:0] mem [0:31];
  logic        pre_en;
  logic [4:0]  pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_en)         mem[pre_addr] <= pre_data;
    else if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en)      mem_rd_data <= mem[mem_rd_addr];
  end

  // Activity monitor
  int          wr_cnt = 0, rd_cnt = 0, acc_cnt = 0, both_cnt = 0;
  logic [4:0]  last_wr_addr;
  logic [31:0] last_wr_data;

  always @(posedge clk) begin
    if (mem_wr_en) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= mem_wr_addr;
      last_wr_data <= mem_wr_data;
    end
    if (mem_rd_en) rd_cnt <= rd_cnt + 1;
    if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
    if (req_valid && req_ready && !rst) acc_cnt <= acc_cnt + 1;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Push expectation, drive one request, measure latency, pop and compare on the response
  task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [6:0] addr, input logic [31:0] wdata,
                        input logic [31:0] e_rdata, input logic e_err, input int e_lat);
    exp_t e;
    int   n;
    bit   got;
    e.rdata = e_rdata; e.err = e_err; e.lat = e_lat;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk({tag, "_accept_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      void'(sb.pop_front());
      return;
    end
    @(posedge clk);
    n = 0; got = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clk);
      req_valid = 1'b0;
      n++;
      if (resp_valid) got = 1'b1;
    end
    e = sb.pop_front();
    if (!got) begin
      chk({tag, "_resp_timeout"}, 32'(resp_valid), 32'd1);
      return;
    end
    chk({tag, "_latency"}, 32'(n), 32'(e.lat));
    chk({tag, "_rdata"}, resp_rdata, e.rdata);
    chk({tag, "_err"}, 32'(resp_err), 32'(e.err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int wr0, rd0, acc0;
    exp_t e;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 7'd0; req_wdata = 32'd0; pre_en = 1'b0; pre_addr = 5'd0; pre_data = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_rdata", resp_rdata, 32'd0);
    chk("reset_resp_err", 32'(resp_err), 32'd0);
    chk("reset_mem_en", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);

    // Word store then word load at 0x08
    wr0 = wr_cnt;
    do_req("st_word", 1'b1, 2'b10, 1'b0, 7'h08, 32'hDEADBEEF, 32'd0, 1'b0, 2);
    chk("st_word_wr_count", 32'(wr_cnt - wr0), 32'd1);
    chk("st_word_wr_addr", 32'(last_wr_addr), 32'd2);
    chk("st_word_wr_data", last_wr_data, 32'hDEADBEEF);
    do_req("ld_word", 1'b0, 2'b10, 1'b0, 7'h08, 32'd0, 32'hDEADBEEF, 1'b0, 3);

    // Sub-word stores merge into word 5
    preload(5'd5, 32'h11223344);
    wr0 = wr_cnt; rd0 = rd_cnt;
    do_req("st_byte", 1'b1, 2'b00, 1'b0, 7'h15, 32'h000000AA, 32'd0, 1'b0, 4);
    chk("st_byte_rd_count", 32'(rd_cnt - rd0), 32'd1);
    chk("st_byte_wr_count", 32'(wr_cnt - wr0), 32'd1);
    chk("st_byte_wr_data", last_wr_data, 32'h1122AA44);
    chk("st_byte_wr_addr", 32'(last_wr_addr), 32'd5);
    do_req("st_half", 1'b1, 2'b01, 1'b0, 7'h16, 32'h1234BEEF, 32'd0, 1'b0, 4);
    @(negedge clk);
    chk("st_half_mem", mem[5], 32'hBEEFAA44);

    // Extraction and extension from word 3
    preload(5'd3, 32'h80FF7F01);
    do_req("ld_b0e_s", 1'b0, 2'b00, 1'b0, 7'h0E, 32'd0, 32'hFFFFFFFF, 1'b0, 3);
    do_req("ld_b0e_u", 1'b0, 2'b00, 1'b1, 7'h0E, 32'd0, 32'h000000FF, 1'b0, 3);
    do_req("ld_h0e_s", 1'b0, 2'b01, 1'b0, 7'h0E, 32'd0, 32'hFFFF80FF, 1'b0, 3);
    do_req("ld_b0d_s", 1'b0, 2'b00, 1'b0, 7'h0D, 32'd0, 32'h0000007F, 1'b0, 3);
    do_req("ld_b0f_s", 1'b0, 2'b00, 1'b0, 7'h0F, 32'd0, 32'hFFFFFF80, 1'b0, 3);
    do_req("ld_h0c_u", 1'b0, 2'b01, 1'b1, 7'h0C, 32'd0, 32'h00007F01, 1'b0, 3);
    do_req("ld_h0c_s", 1'b0, 2'b01, 1'b0, 7'h0C, 32'd0, 32'h00007F01, 1'b0, 3);
    do_req("ld_size3", 1'b0, 2'b11, 1'b0, 7'h0C, 32'd0, 32'h80FF7F01, 1'b0, 3);

    // Back-to-back loads with req_valid held high
    e.rdata = 32'hDEADBEEF; e.err = 1'b0; e.lat = 3;
    sb.push_back(e);
    sb.push_back(e);
    @(negedge clk);
    acc0 = acc_cnt; rd0 = rd_cnt;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 7'h08;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("b2b_ready_%0d", i), 32'(req_ready), 32'((i % 4) == 0));
      chk($sformatf("b2b_resp_%0d", i), 32'(resp_valid), 32'((i % 4) == 3));
      if (resp_valid && sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("b2b_rdata_%0d", i), resp_rdata, e.rdata);
      end
      if (i == 7) req_valid = 1'b0;
    end
    @(negedge clk);
    chk("b2b_accepts", 32'(acc_cnt - acc0), 32'd2);
    chk("b2b_reads", 32'(rd_cnt - rd0), 32'd2);
    chk("b2b_sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();

    // Reset asserted during WR of a byte store
    preload(5'd7, 32'h01020304);
    @(negedge clk);
    wr0 = wr_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 7'h1C; req_wdata = 32'h000000FF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstwr_in_wr", 32'(mem_wr_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstwr_wr_gated", 32'(mem_wr_en), 32'd0);
    chk("rstwr_resp_gated", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstwr_mem_kept", mem[7], 32'h01020304);
    chk("rstwr_no_write", 32'(wr_cnt - wr0), 32'd0);
    chk("rstwr_ready", 32'(req_ready), 32'd1);
    chk("rstwr_outputs", {resp_rdata[29:0], resp_valid, resp_err}, 32'd0);
    chk("rstwr_mem_en", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);

    // Misaligned word load
    rd0 = rd_cnt;
`ifdef LSU_MISALIGN_CHECK_EN
    do_req("ld_misalign", 1'b0, 2'b10, 1'b0, 7'h09, 32'd0, 32'd0, 1'b1, 1);
    chk("ld_misalign_no_rd", 32'(rd_cnt - rd0), 32'd0);
`else
    do_req("ld_misalign", 1'b0, 2'b10, 1'b0, 7'h09, 32'd0, 32'hDEADBEEF, 1'b0, 3);
    chk("ld_misalign_rd", 32'(rd_cnt - rd0), 32'd1);
`endif

    chk("rd_wr_overlap", 32'(both_cnt), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
